// File: rtl/sub_serial64.sv
// Bit-serial subtractor (diff = a - b), one bit per clock, LSB first.
// Produces the final borrow and ZF/SF/OF condition codes when the result completes.
module sub_serial64 #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             borrow_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] diff_q;
   logic             busy_q;
   logic             done_q;
   logic             bout_q;
   logic             zf_q;
   logic             sf_q;
   logic             of_q;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             borrow_d;
   logic [WIDTH-1:0] res_d;
   logic             last_bit;

   function automatic logic fs_diff(input logic x, input logic y, input logic bin);
      return x ^ y ^ bin;
   endfunction

   function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
      return (~x & y) | (~(x ^ y) & bin);
   endfunction

   assign a_bit    = a_sh_q[0];
   assign b_bit    = b_sh_q[0];
   assign d_bit    = fs_diff(a_bit, b_bit, borrow_q);
   assign borrow_d = fs_borrow(a_bit, b_bit, borrow_q);
   assign res_d    = {d_bit, res_q[WIDTH-1:1]};
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bout_q   <= 1'b0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_sh_q   <= a;
                  b_sh_q   <= b;
                  borrow_q <= 1'b0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               res_q    <= res_d;
               borrow_q <= borrow_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  // At the final bit the shift registers hold the operand MSBs.
                  diff_q  <= res_d;
                  bout_q  <= borrow_d;
                  zf_q    <= (res_d == '0);
                  sf_q    <= d_bit;
                  of_q    <= (a_bit != b_bit) && (d_bit != a_bit);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign zf   = zf_q;
   assign sf   = sf_q;
   assign of   = of_q;

endmodule

// File: tb/tb_sub_serial64.sv
// Bench for sub_serial64: fixed vector table, random operands against an
// arithmetic reference model, and multi-cycle corner sequences.
module tb_sub_serial64;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, bout, zf, sf, of;
   logic [W-1:0] diff;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   sub_serial64 #(.WIDTH(W), .CNT_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .bout(bout),
      .zf(zf), .sf(sf), .of(of)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (done) done_cnt = done_cnt + 1;
   end

   typedef struct {
      string        name;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] ed;
      logic         ebo;
      logic         ez;
      logic         es;
      logic         eo;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_flags(input string pfx, input logic [W-1:0] ed,
                              input logic ebo, input logic ez, input logic es, input logic eo);
      check({pfx, "_diff"}, diff, ed);
      check({pfx, "_bout"}, 64'(bout), 64'(ebo));
      check({pfx, "_zf"},   64'(zf),   64'(ez));
      check({pfx, "_sf"},   64'(sf),   64'(es));
      check({pfx, "_of"},   64'(of),   64'(eo));
   endtask

   // Reference: wide unsigned and signed subtraction.
   task automatic check_model(input string pfx, input logic [W-1:0] av, input logic [W-1:0] bv);
      logic [W:0]        u;
      logic signed [W:0] s;
      logic [W-1:0]      ed;
      u  = {1'b0, av} - {1'b0, bv};
      s  = $signed({av[W-1], av}) - $signed({bv[W-1], bv});
      ed = u[W-1:0];
      check_flags(pfx, ed, u[W], ed == '0, ed[W-1], s[W] ^ s[W-1]);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done && lat < 200);
   endtask

   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while ((busy || done) && g < 200) begin
         @(negedge clk);
         g++;
      end
   endtask

   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
      wait_idle();
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      check("busy_after_accept", 64'(busy), 64'd1);
      wait_done(lat);
   endtask

   initial begin
      int           lat, t1, t2, dc0, sel;
      logic [W-1:0] ra, rb;

      tbl[0] = '{"t1_5m3",   64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{"t2_3m5",   64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{"t3_eq",    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{"t4_minm1", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{"zero_m1",  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{"max_mneg", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check_flags("rst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_op(tbl[i].va, tbl[i].vb, lat);
         check({tbl[i].name, "_latency"}, 64'(lat), 64'd64);
         check({tbl[i].name, "_busy_in_done"}, 64'(busy), 64'd0);
         check_flags(tbl[i].name, tbl[i].ed, tbl[i].ebo, tbl[i].ez, tbl[i].es, tbl[i].eo);
      end

      for (int i = 0; i < 20; i++) begin
         sel = $urandom_range(0, 4);
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         if (sel == 1) rb = ra;
         if (sel == 2) ra = '0;
         if (sel == 3) rb = {1'b1, rb[W-2:0]};
         do_op(ra, rb, lat);
         check("rnd_latency", 64'(lat), 64'd64);
         check_model("rnd", ra, rb);
      end

      // Start pulsed mid-run with new operands must be ignored.
      wait_idle();
      a = 64'd5; b = 64'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dc0 = done_cnt;
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1; a = 64'hFFFF; b = 64'h1234_0000;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat);
      check("t5_latency", 64'(lat + 11), 64'd64);
      check_flags("t5", 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (70) @(posedge clk);
      #1;
      check("t5_single_done", 64'(done_cnt - dc0), 64'd1);
      check("t5_no_restart", 64'(busy), 64'd0);

      // Reset in the middle of a run.
      wait_idle();
      a = 64'd99; b = 64'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_done", 64'(done), 64'd0);
      check_flags("t6", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      dc0 = done_cnt;
      repeat (80) @(posedge clk);
      #1;
      check("t6_no_done", 64'(done_cnt - dc0), 64'd0);
      do_op(64'd0, 64'd1, lat);
      check("t6_next_latency", 64'(lat), 64'd64);
      check_flags("t6_next", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);

      // Back-to-back with start held high.
      wait_idle();
      a = 64'd1000; b = 64'd1; start = 1'b1;
      @(posedge clk); #1;
      a = 64'd1; b = 64'd1000;
      wait_done(lat);
      t1 = cyc;
      check_model("b2b_first", 64'd1000, 64'd1);
      @(posedge clk); #1;
      check("b2b_idle_done", 64'(done), 64'd0);
      check("b2b_idle_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("b2b_reaccept", 64'(busy), 64'd1);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("b2b_hold_diff", diff, 64'd999);
      wait_done(lat);
      t2 = cyc;
      check("b2b_period", 64'(t2 - t1), 64'd66);
      check_model("b2b_second", 64'd1, 64'd1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
